// File: rtl/mult_sequencer_pkg.sv
// Shared types and constants for the MULT/MULTU sequencer: FSM state encodings,
// default operand width and the MIPS func codes that drive it.
package mult_sequencer_pkg;

  localparam int unsigned DATA_W = 32;

  typedef enum logic [1:0] {
    MS_IDLE = 2'd0,
    MS_BUSY = 2'd1,
    MS_FIX  = 2'd2
  } ms_state_e;

  localparam logic [5:0] FUNC_MFHI  = 6'h10;
  localparam logic [5:0] FUNC_MFLO  = 6'h12;
  localparam logic [5:0] FUNC_MULT  = 6'h18;
  localparam logic [5:0] FUNC_MULTU = 6'h19;

endpackage

// File: rtl/mult_sequencer_if.sv
// Decode-side request / HI-LO response bundle between the control unit and the
// multiply sequencer.
interface mult_sequencer_if
  import mult_sequencer_pkg::*;
#(
  parameter int unsigned WIDTH = DATA_W
) ();

  logic             mult_en;
  logic             mult_sign;
  logic [WIDTH-1:0] rs_data;
  logic [WIDTH-1:0] rt_data;
  logic             mfhi_req;
  logic             mflo_req;
  logic             stall;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (
    output mult_en, mult_sign, rs_data, rt_data, mfhi_req, mflo_req,
    input  stall, busy, done, hi, lo
  );

  modport slave (
    input  mult_en, mult_sign, rs_data, rt_data, mfhi_req, mflo_req,
    output stall, busy, done, hi, lo
  );

endinterface

// File: rtl/mult_datapath.sv
// Shift-add datapath: operand magnitudes, 2*WIDTH accumulator and final sign fix.
// Build option MULT_EARLY_TERM_EN ends the loop once the remaining multiplier is zero.
module mult_datapath
  import mult_sequencer_pkg::*;
#(
  parameter int unsigned WIDTH = DATA_W
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               load,
  input  logic               step,
  input  logic               sign,
  input  logic [WIDTH-1:0]   rs,
  input  logic [WIDTH-1:0]   rt,
  input  logic               count_last,
  output logic               last_c,
  output logic [2*WIDTH-1:0] product_c
);

  localparam int unsigned PW = 2 * WIDTH;

  logic [PW-1:0]    acc;
  logic [PW-1:0]    mcand;
  logic [WIDTH-1:0] mplier;
  logic             neg;
  logic [WIDTH-1:0] rs_mag;
  logic [WIDTH-1:0] rt_mag;

  // Magnitudes are taken modulo 2^WIDTH, so the most-negative value maps to 2^(WIDTH-1).
  assign rs_mag = (sign && rs[WIDTH-1]) ? (~rs + WIDTH'(1)) : rs;
  assign rt_mag = (sign && rt[WIDTH-1]) ? (~rt + WIDTH'(1)) : rt;

  always_ff @(posedge clk) begin
    if (rst) begin
      acc    <= '0;
      mcand  <= '0;
      mplier <= '0;
      neg    <= 1'b0;
    end else if (load) begin
      acc    <= '0;
      mcand  <= PW'(rs_mag);
      mplier <= rt_mag;
      neg    <= sign & (rs[WIDTH-1] ^ rt[WIDTH-1]);
    end else if (step) begin
      if (mplier[0]) acc <= acc + mcand;
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
    end
  end

`ifdef MULT_EARLY_TERM_EN
  assign last_c = count_last | (mplier[WIDTH-1:1] == '0);
`else
  assign last_c = count_last;
`endif

  assign product_c = neg ? (~acc + PW'(1)) : acc;

endmodule

// File: rtl/mult_sequencer.sv
// MULT/MULTU sequencer top: FSM, step counter, pipeline stall and the HI/LO pair.
// Timing depends on build option MULT_EARLY_TERM_EN (see mult_datapath).
module mult_sequencer
  import mult_sequencer_pkg::*;
#(
  parameter int unsigned WIDTH = DATA_W
) (
  input logic             clk,
  input logic             rst,
  mult_sequencer_if.slave bus
);

  localparam int unsigned CNT_W = $clog2(WIDTH);

  ms_state_e          state;
  ms_state_e          state_next;
  logic [CNT_W-1:0]   count;
  logic [WIDTH-1:0]   hi;
  logic [WIDTH-1:0]   lo;
  logic               done;
  logic               load_c;
  logic               step_c;
  logic               fix_c;
  logic               count_last_c;
  logic               last_c;
  logic [2*WIDTH-1:0] product_c;

  assign count_last_c = (count == CNT_W'(WIDTH - 1));

  mult_datapath #(.WIDTH(WIDTH)) u_datapath (
    .clk        (clk),
    .rst        (rst),
    .load       (load_c),
    .step       (step_c),
    .sign       (bus.mult_sign),
    .rs         (bus.rs_data),
    .rt         (bus.rt_data),
    .count_last (count_last_c),
    .last_c     (last_c),
    .product_c  (product_c)
  );

  always_comb begin
    state_next = state;
    load_c     = 1'b0;
    step_c     = 1'b0;
    fix_c      = 1'b0;
    case (state)
      MS_IDLE: begin
        if (bus.mult_en) begin
          load_c     = 1'b1;
          state_next = MS_BUSY;
        end
      end
      MS_BUSY: begin
        step_c = 1'b1;
        if (last_c) state_next = MS_FIX;
      end
      MS_FIX: begin
        fix_c      = 1'b1;
        state_next = MS_IDLE;
      end
      default: state_next = MS_IDLE;
    endcase
  end

  // HI/LO only change as a pair on the FIX->IDLE edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= MS_IDLE;
      count <= '0;
      hi    <= '0;
      lo    <= '0;
      done  <= 1'b0;
    end else begin
      state <= state_next;
      done  <= fix_c;
      if (load_c)      count <= '0;
      else if (step_c) count <= count + CNT_W'(1);
      if (fix_c) {hi, lo} <= product_c;
    end
  end

  assign bus.busy  = (state != MS_IDLE);
  assign bus.stall = (state != MS_IDLE) & (bus.mfhi_req | bus.mflo_req | bus.mult_en);
  assign bus.done  = done;
  assign bus.hi    = hi;
  assign bus.lo    = lo;

endmodule
